param_ram: RTL and testbench
============================

Name: param_ram

Overview:
- Parametrised single-port synchronous RAM. Next generation of the processor's 16-bit word memory.
- Adds configurable width, depth and read latency, byte-lane write enables, a read-valid strobe, and a hardware clear-on-reset sequencer.
- Runs on the system clock; there is no private memory clock.
- Sits between the processor datapath and the memory address/data buses.

Parameters:
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 8: address width; depth = 2**ADDR_W words.
- READ_LAT, 1: read latency in cycles; legal values are 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents undefined after power-up and preserved across reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  request strobe; one request per cycle while high.
- rw  input  1  1 = read, 0 = write.
- addr  input  ADDR_W  word address.
- A  input  DATA_W  write data.
- be  input  DATA_W/8  byte-lane write enables; bit i covers A[8i+7:8i].
- Q  output  DATA_W  read data.
- valid  output  1  Q holds the result of a read, for exactly one cycle.
- busy  output  1  block is clearing; requests are ignored.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - Q = 0, valid = 0, read pipeline flushed.
  - Clear counter = 0.
  - busy = 1 if CLEAR_ON_RESET = 1, else busy = 0.
  - Memory array is not reset asynchronously.
- State machine, states CLEAR and READY:
  - On reset release, enter CLEAR if CLEAR_ON_RESET = 1, else READY.
  - CLEAR: each cycle write 0 to word[counter], then increment counter. After writing word 2**ADDR_W-1, go to READY on the next edge. CLEAR lasts exactly 2**ADDR_W cycles after reset deassertion.
  - busy = 1 throughout CLEAR; busy = 0 on the first READY cycle.
  - READY: persists until the next rst.
- Requests in CLEAR are ignored: no write, no valid.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- Write (READY, en = 1, rw = 0):
  - At the edge, for each i with be[i] = 1, word[addr] byte i <= A byte i. Bytes with be[i] = 0 are unchanged.
  - be = 0 is a legal no-op.
  - Q and valid are unaffected.
- Read (READY, en = 1, rw = 1):
  - be is ignored.
  - READ_LAT = 1: Q = word[addr] and valid = 1 in the cycle after the request edge.
  - READ_LAT = 2: one extra register stage, so Q and valid appear one cycle later.
  - Back-to-back reads: one result per cycle, in order.
- Q holds its last read value when valid = 0. valid is never high without a corresponding read request.
- Write then read of the same address on the next cycle returns the newly written data. There is no stale-read hazard because the single port serialises accesses.
- Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.
- Reset asserted with reads in flight: Q = 0, valid = 0 immediately; in-flight results are lost.
- en = 0: no array access; the pipeline advances and valid deasserts when it drains.
- Target implementation size: 120-400 lines of RTL.

Test Plan:
- Clear (DATA_W = 16, ADDR_W = 4, CLEAR_ON_RESET = 1):
  - Stimulus: rst pulse, then a write of 0xFFFF to address 3 during CLEAR.
  - Required: busy = 1 for exactly 16 cycles after rst falls. After busy falls, reading every address gives 0x0000, including address 3.
- Byte enables:
  - Stimulus: write A = 0xABCD, be = 2'b11 to address 0x05; then write A = 0x1234, be = 2'b01 to 0x05; then read 0x05.
  - Required: Q = 0xAB34 with valid = 1 one cycle after the read (READ_LAT = 1).
- Latency and throughput (READ_LAT = 2):
  - Stimulus: preload word[k] = k. Read addresses 1, 2, 3 on consecutive cycles.
  - Required: valid high for 3 consecutive cycles starting 2 cycles after the first read, with Q = 0x0001, 0x0002, 0x0003.
- Write-then-read:
  - Stimulus: write 0x5A5A to 0xFF (ADDR_W = 8), then read 0xFF on the next cycle.
  - Required: Q = 0x5A5A, valid = 1.
- Reset mid-operation:
  - Stimulus: issue a read, then assert rst before the data returns.
  - Required: valid = 0 and Q = 0 immediately with no stale pulse, and CLEAR restarts from address 0 (busy = 1).
- CLEAR_ON_RESET = 0:
  - Stimulus: write 0x00C3 to address 7, pulse rst, read address 7.
  - Required: busy stays 0 throughout, and Q = 0x00C3 (contents retained across reset).

Source files
------------

// File: rtl/param_ram_if.sv
// Request/response bus of param_ram: processor-side request fields plus the
// read data, read-valid strobe and clear-in-progress indication.
interface param_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  en;
  logic                  rw;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     A;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     Q;
  logic                  valid;
  logic                  busy;

  modport master (output en, rw, addr, A, be, input Q, valid, busy);
  modport slave  (input en, rw, addr, A, be, output Q, valid, busy);
endinterface

// File: rtl/param_ram.sv
// Single-port synchronous word RAM with byte-lane writes, 1- or 2-cycle read
// latency, read-valid strobe and an optional zero-fill sequence after reset.
module param_ram #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        rst,
  param_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_en, rd_en;
  logic                rd_v1;
  logic [DATA_W-1:0]   rd_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state)
      CLEAR: if (&clr_cnt) state_next = READY;
      READY: begin
        wr_en = bus.en && !bus.rw;
        rd_en = bus.en &&  bus.rw;
      end
      default: state_next = READY;
    endcase
  end

  assign bus.busy = (state == CLEAR);

  // Array has no reset; clearing is done one word per cycle by the sequencer.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.A[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else begin
      rd_v1 <= rd_en;
      if (rd_en) rd_d1 <= mem[bus.addr];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;

      // Data register only loads on a valid beat so Q holds between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) rd_d2 <= rd_d1;
        end
      end

      assign bus.Q     = rd_d2;
      assign bus.valid = rd_v2;
    end else begin : g_lat1
      assign bus.Q     = rd_d1;
      assign bus.valid = rd_v1;
    end
  endgenerate
endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: three instances cover clear-on-reset, byte
// lanes, 2-cycle latency, reset with a read in flight, and retention mode.
module tb_param_ram;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  always #5 clk = ~clk;

  param_ram_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
  param_ram_if #(.DATA_W(16), .ADDR_W(8)) ifb ();
  param_ram_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

  param_ram #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1))
    u_a (.clk(clk), .rst(rst_a), .bus(ifa));
  param_ram #(.DATA_W(16), .ADDR_W(8), .READ_LAT(2), .CLEAR_ON_RESET(1))
    u_b (.clk(clk), .rst(rst_b), .bus(ifb));
  param_ram #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(0))
    u_c (.clk(clk), .rst(rst_c), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.en = 0; ifa.rw = 0; ifa.addr = '0; ifa.A = '0; ifa.be = '0;
    ifb.en = 0; ifb.rw = 0; ifb.addr = '0; ifb.A = '0; ifb.be = '0;
    ifc.en = 0; ifc.rw = 0; ifc.addr = '0; ifc.A = '0; ifc.be = '0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    tick(); tick();

    check("rst_a_Q", 32'(ifa.Q), 32'h0);
    check("rst_a_valid", 32'(ifa.valid), 32'h0);
    check("rst_a_busy", 32'(ifa.busy), 32'h1);
    check("rst_b_busy", 32'(ifb.busy), 32'h1);
    check("rst_c_busy", 32'(ifc.busy), 32'h0);
    check("rst_c_valid", 32'(ifc.valid), 32'h0);

    rst_a = 0; rst_b = 0; rst_c = 0;

    // Write to address 3 during CLEAR must be ignored.
    ifa.en = 1; ifa.rw = 0; ifa.addr = 4'd3; ifa.A = 16'hFFFF; ifa.be = 2'b11;
    n = 0;
    while (ifa.busy && n < 40) begin
      n++;
      tick();
      ifa.en = 0;
    end
    check("a_clear_len", 32'(n), 32'd16);
    check("a_clear_valid", 32'(ifa.valid), 32'h0);

    for (int k = 0; k < 16; k++) begin
      ifa.en = 1; ifa.rw = 1; ifa.addr = 4'(k);
      tick();
      check($sformatf("a_clr_Q%0d", k), 32'(ifa.Q), 32'h0);
      check($sformatf("a_clr_v%0d", k), 32'(ifa.valid), 32'h1);
    end
    ifa.en = 0;
    tick();
    check("a_drain_valid", 32'(ifa.valid), 32'h0);

    // Byte lanes: full write then low-lane-only write.
    ifa.en = 1; ifa.rw = 0; ifa.addr = 4'h5; ifa.A = 16'hABCD; ifa.be = 2'b11;
    tick();
    ifa.A = 16'h1234; ifa.be = 2'b01;
    tick();
    check("a_wr_valid", 32'(ifa.valid), 32'h0);
    ifa.rw = 1; ifa.be = 2'b00;
    tick();
    check("a_be_Q", 32'(ifa.Q), 32'hAB34);
    check("a_be_valid", 32'(ifa.valid), 32'h1);
    ifa.rw = 0; ifa.A = 16'hFFFF; ifa.be = 2'b00;
    tick();
    check("a_hold_Q", 32'(ifa.Q), 32'hAB34);
    check("a_hold_valid", 32'(ifa.valid), 32'h0);
    ifa.rw = 1;
    tick();
    ifa.en = 0;
    check("a_be0_Q", 32'(ifa.Q), 32'hAB34);
    check("a_be0_valid", 32'(ifa.valid), 32'h1);

    // Retention across reset with CLEAR_ON_RESET = 0.
    check("c_ready_busy", 32'(ifc.busy), 32'h0);
    ifc.en = 1; ifc.rw = 0; ifc.addr = 4'd7; ifc.A = 16'h00C3; ifc.be = 2'b11;
    tick();
    ifc.en = 0;
    rst_c = 1;
    tick();
    check("c_rst_busy", 32'(ifc.busy), 32'h0);
    check("c_rst_valid", 32'(ifc.valid), 32'h0);
    rst_c = 0;
    ifc.en = 1; ifc.rw = 1; ifc.addr = 4'd7;
    tick();
    ifc.en = 0;
    check("c_keep_Q", 32'(ifc.Q), 32'h00C3);
    check("c_keep_valid", 32'(ifc.valid), 32'h1);
    check("c_keep_busy", 32'(ifc.busy), 32'h0);

    // Instance b: 256-word clear was running in parallel.
    n = 0;
    while (ifb.busy && n < 300) begin
      n++;
      tick();
    end
    check("b_clear_done", 32'(ifb.busy), 32'h0);

    for (int k = 1; k <= 3; k++) begin
      ifb.en = 1; ifb.rw = 0; ifb.addr = 8'(k); ifb.A = 16'(k); ifb.be = 2'b11;
      tick();
    end
    ifb.rw = 1; ifb.addr = 8'd1;
    tick();
    check("b_lat_v0", 32'(ifb.valid), 32'h0);
    ifb.addr = 8'd2;
    tick();
    check("b_lat_Q1", 32'(ifb.Q), 32'h0001);
    check("b_lat_v1", 32'(ifb.valid), 32'h1);
    ifb.addr = 8'd3;
    tick();
    ifb.en = 0;
    check("b_lat_Q2", 32'(ifb.Q), 32'h0002);
    check("b_lat_v2", 32'(ifb.valid), 32'h1);
    tick();
    check("b_lat_Q3", 32'(ifb.Q), 32'h0003);
    check("b_lat_v3", 32'(ifb.valid), 32'h1);
    tick();
    check("b_lat_end_v", 32'(ifb.valid), 32'h0);
    check("b_lat_end_Q", 32'(ifb.Q), 32'h0003);

    // Write then read of the top address.
    ifb.en = 1; ifb.rw = 0; ifb.addr = 8'hFF; ifb.A = 16'h5A5A; ifb.be = 2'b11;
    tick();
    ifb.rw = 1;
    tick();
    ifb.en = 0;
    check("b_wtr_v_early", 32'(ifb.valid), 32'h0);
    tick();
    check("b_wtr_Q", 32'(ifb.Q), 32'h5A5A);
    check("b_wtr_valid", 32'(ifb.valid), 32'h1);
    tick();

    // Reset with a read in flight.
    ifb.en = 1; ifb.rw = 1; ifb.addr = 8'hFF;
    tick();
    ifb.en = 0;
    check("b_inflight_v", 32'(ifb.valid), 32'h0);
    #2 rst_b = 1;
    #1;
    check("b_rst_Q", 32'(ifb.Q), 32'h0);
    check("b_rst_valid", 32'(ifb.valid), 32'h0);
    check("b_rst_busy", 32'(ifb.busy), 32'h1);
    tick();
    check("b_rst_valid2", 32'(ifb.valid), 32'h0);
    rst_b = 0;
    n = 0;
    while (ifb.busy && n < 300) begin
      n++;
      tick();
      if (ifb.valid) check("b_stale_valid", 32'(ifb.valid), 32'h0);
    end
    check("b_reclear_len", 32'(n), 32'd256);
    check("b_reclear_Q", 32'(ifb.Q), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
